// File: rtl/mtm_pkg.sv
// Shared encodings for the tiled matmul memory controller.
package mtm_pkg;

    localparam logic [1:0] MAT_A = 2'd0;
    localparam logic [1:0] MAT_B = 2'd1;
    localparam logic [1:0] MAT_C = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned RD_LAT = 3;

endpackage

// File: rtl/mtm_bank.sv
// One memory bank: registered host/alternate address mux, RAM, registered read port.
module mtm_bank #(
    parameter int unsigned WW     = 512,
    parameter int unsigned AWIDTH = 7
) (
    input  logic              clk_mem,
    input  logic              reset,
    input  logic              i_host_sel,
    input  logic              i_host_we,
    input  logic [AWIDTH-1:0] i_host_addr,
    input  logic [WW-1:0]     i_host_wdata,
    input  logic [AWIDTH-1:0] i_alt_addr,
    input  logic              i_alt_we,
    input  logic [WW-1:0]     i_alt_wdata,
    output logic [WW-1:0]     o_ram_dout,
    output logic [WW-1:0]     o_rdata
);

    logic [AWIDTH-1:0] r_addr;
    logic              r_we;
    logic [WW-1:0]     r_wdata;
    logic [WW-1:0]     r_rdata;
    logic [WW-1:0]     w_ram_dout;

    // Host access wins the bank whenever it targets it; otherwise the engine/capture side drives it.
    always_ff @(posedge clk_mem) begin
        if (reset) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_addr  <= i_host_sel ? i_host_addr  : i_alt_addr;
            r_we    <= i_host_sel ? i_host_we    : i_alt_we;
            r_wdata <= i_host_sel ? i_host_wdata : i_alt_wdata;
        end
    end

    single_port_ram #(
        .WIDTH  (WW),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clk     (clk_mem),
        .i_we    (r_we),
        .i_addr  (r_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_dout)
    );

    always_ff @(posedge clk_mem) begin
        if (reset) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_ram_dout;
        end
    end

    assign o_ram_dout = w_ram_dout;
    assign o_rdata    = r_rdata;

endmodule

// File: rtl/single_port_ram.sv
// Single-port RAM with registered read data; contents are never reset.
module single_port_ram #(
    parameter int unsigned WIDTH  = 512,
    parameter int unsigned AWIDTH = 7
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AWIDTH-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_wdata,
    output logic [WIDTH-1:0]  o_rdata
);

    localparam int unsigned DEPTH = 1 << AWIDTH;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/matmul_tile_mem_ctrl.sv
// Banked A/B/C tile memory for a systolic fp16 matmul array: host load/readback,
// engine A/B reads and counted C-row capture under a run FSM.
module matmul_tile_mem_ctrl
    import mtm_pkg::*;
#(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned TILE   = 32,
    parameter int unsigned AWIDTH = 7,
    parameter int unsigned NUM_A  = 2,
    parameter int unsigned NUM_B  = 2,
    parameter int unsigned NUM_C  = 2,
    parameter int unsigned C_ROWS = 64,
    parameter int unsigned BSEL_W = 2
) (
    input  logic                           clk_mem,
    input  logic                           reset,
    input  logic                           host_wr_en,
    input  logic                           host_rd_req,
    input  logic [1:0]                     host_mat,
    input  logic [BSEL_W-1:0]              host_bank,
    input  logic [AWIDTH-1:0]              host_addr,
    input  logic [TILE*DWIDTH-1:0]         host_wdata,
    output logic [TILE*DWIDTH-1:0]         host_rdata,
    output logic                           host_rd_valid,
    output logic                           host_err,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    input  logic [NUM_A*AWIDTH-1:0]        eng_a_addr,
    output logic [NUM_A*TILE*DWIDTH-1:0]   eng_a_data,
    input  logic [NUM_B*AWIDTH-1:0]        eng_b_addr,
    output logic [NUM_B*TILE*DWIDTH-1:0]   eng_b_data,
    input  logic                           eng_c_valid,
    input  logic [NUM_C*TILE*DWIDTH-1:0]   eng_c_data
);

    localparam int unsigned WW    = TILE * DWIDTH;
    localparam int unsigned NB    = NUM_A + NUM_B + NUM_C;
    localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AWIDTH-1:0] r_c_wptr;
    logic [AWIDTH-1:0] w_c_wptr_nxt;
    logic              w_c_we;

    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_rd_v1;
    logic              r_rd_v2;
    logic              r_rd_valid;
    logic [IDX_W-1:0]  r_rd_idx1;
    logic [IDX_W-1:0]  r_rd_idx2;
    logic [WW-1:0]     r_rdata;

    logic              w_sel_legal;
    int unsigned       w_base;
    logic [IDX_W-1:0]  w_flat_idx;
    logic              w_host_ok;
    logic              w_wr_go;
    logic              w_rd_go;
    logic              w_host_go;
    logic              w_err;
    logic [NB-1:0]     w_bank_sel;
    logic [WW-1:0]     w_bank_dout  [NB];
    logic [WW-1:0]     w_bank_rdata [NB];
    logic [WW-1:0]     w_host_dout;
    logic [NUM_C*WW-1:0] w_unused_c_rdata;

    // Decode host select into a flat bank index; banks are laid out A, then B, then C.
    always_comb begin
        w_sel_legal = 1'b0;
        w_base      = 0;
        case (host_mat)
            MAT_A: begin
                w_sel_legal = 32'(host_bank) < NUM_A;
                w_base      = 0;
            end
            MAT_B: begin
                w_sel_legal = 32'(host_bank) < NUM_B;
                w_base      = NUM_A;
            end
            MAT_C: begin
                w_sel_legal = 32'(host_bank) < NUM_C;
                w_base      = NUM_A + NUM_B;
            end
            default: begin
                w_sel_legal = 1'b0;
                w_base      = 0;
            end
        endcase
    end

    assign w_flat_idx = IDX_W'(w_base + 32'(host_bank));
    assign w_host_ok  = (r_state == IDLE) && !start;
    assign w_wr_go    = host_wr_en && w_host_ok && w_sel_legal;
    assign w_rd_go    = host_rd_req && !host_wr_en && w_host_ok && w_sel_legal;
    assign w_host_go  = w_wr_go || w_rd_go;
    assign w_err      = (host_wr_en && !w_wr_go) || (host_rd_req && !w_rd_go);

    // Run FSM and C capture pointer.
    always_ff @(posedge clk_mem) begin
        if (reset) begin
            r_state  <= IDLE;
            r_c_wptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_c_wptr <= w_c_wptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_c_wptr_nxt = r_c_wptr;
        w_c_we       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt  = RUN;
                    w_c_wptr_nxt = '0;
                end
            end
            RUN: begin
                if (eng_c_valid) begin
                    w_c_we       = 1'b1;
                    w_c_wptr_nxt = r_c_wptr + AWIDTH'(1);
                    if (r_c_wptr == AWIDTH'(C_ROWS - 1)) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    generate
        for (genvar j = 0; j < NB; j++) begin : g_bank
            logic [AWIDTH-1:0] w_alt_addr;
            logic              w_alt_we;
            logic [WW-1:0]     w_alt_wdata;

            assign w_bank_sel[j] = w_host_go && (w_flat_idx == IDX_W'(j));

            if (j < NUM_A) begin : g_a
                assign w_alt_addr  = eng_a_addr[j*AWIDTH +: AWIDTH];
                assign w_alt_we    = 1'b0;
                assign w_alt_wdata = '0;
                assign eng_a_data[j*WW +: WW] = w_bank_rdata[j];
            end else if (j < NUM_A + NUM_B) begin : g_b
                assign w_alt_addr  = eng_b_addr[(j-NUM_A)*AWIDTH +: AWIDTH];
                assign w_alt_we    = 1'b0;
                assign w_alt_wdata = '0;
                assign eng_b_data[(j-NUM_A)*WW +: WW] = w_bank_rdata[j];
            end else begin : g_c
                assign w_alt_addr  = r_c_wptr;
                assign w_alt_we    = w_c_we;
                assign w_alt_wdata = eng_c_data[(j-NUM_A-NUM_B)*WW +: WW];
                assign w_unused_c_rdata[(j-NUM_A-NUM_B)*WW +: WW] = w_bank_rdata[j];
            end

            mtm_bank #(
                .WW     (WW),
                .AWIDTH (AWIDTH)
            ) u_bank (
                .clk_mem      (clk_mem),
                .reset        (reset),
                .i_host_sel   (w_bank_sel[j]),
                .i_host_we    (w_wr_go),
                .i_host_addr  (host_addr),
                .i_host_wdata (host_wdata),
                .i_alt_addr   (w_alt_addr),
                .i_alt_we     (w_alt_we),
                .i_alt_wdata  (w_alt_wdata),
                .o_ram_dout   (w_bank_dout[j]),
                .o_rdata      (w_bank_rdata[j])
            );
        end
    endgenerate

    // Host read data taken straight from the RAM output of the bank captured two stages back.
    always_comb begin
        w_host_dout = '0;
        for (int unsigned j = 0; j < NB; j++) begin
            if (r_rd_idx2 == IDX_W'(j)) begin
                w_host_dout = w_bank_dout[j];
            end
        end
    end

    always_ff @(posedge clk_mem) begin
        if (reset) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rd_v1    <= 1'b0;
            r_rd_v2    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_idx1  <= '0;
            r_rd_idx2  <= '0;
            r_rdata    <= '0;
        end else begin
            r_busy     <= (w_state_nxt == RUN);
            r_done     <= (w_state_nxt == DONE);
            r_err      <= w_err;
            r_rd_v1    <= w_rd_go;
            r_rd_idx1  <= w_flat_idx;
            r_rd_v2    <= r_rd_v1;
            r_rd_idx2  <= r_rd_idx1;
            r_rd_valid <= r_rd_v2;
            if (r_rd_v2) begin
                r_rdata <= w_host_dout;
            end
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign host_err      = r_err;
    assign host_rd_valid = r_rd_valid;
    assign host_rdata    = r_rdata;

endmodule

// File: tb/tb_matmul_tile_mem_ctrl.sv
// Self-checking bench for matmul_tile_mem_ctrl: host vector table, C capture runs,
// engine read latency and reset corner cases, with a read/err/done scoreboard.
module tb_matmul_tile_mem_ctrl;
    import mtm_pkg::*;

    localparam int unsigned DW  = 16;
    localparam int unsigned TL  = 32;
    localparam int unsigned AW  = 7;
    localparam int unsigned WW  = DW * TL;
    localparam int unsigned NA  = 2;
    localparam int unsigned NBK = 2;
    localparam int unsigned NC  = 2;
    localparam int unsigned CR  = 64;

    logic              clk_mem = 1'b0;
    logic              reset = 1'b1;
    logic              host_wr_en = 1'b0;
    logic              host_rd_req = 1'b0;
    logic [1:0]        host_mat = '0;
    logic [1:0]        host_bank = '0;
    logic [AW-1:0]     host_addr = '0;
    logic [WW-1:0]     host_wdata = '0;
    logic [WW-1:0]     host_rdata;
    logic              host_rd_valid;
    logic              host_err;
    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic [NA*AW-1:0]  eng_a_addr = '0;
    logic [NA*WW-1:0]  eng_a_data;
    logic [NBK*AW-1:0] eng_b_addr = '0;
    logic [NBK*WW-1:0] eng_b_data;
    logic              eng_c_valid = 1'b0;
    logic [NC*WW-1:0]  eng_c_data = '0;

    matmul_tile_mem_ctrl #(
        .DWIDTH (DW), .TILE (TL), .AWIDTH (AW), .NUM_A (NA), .NUM_B (NBK),
        .NUM_C (NC), .C_ROWS (CR), .BSEL_W (2)
    ) dut (
        .clk_mem       (clk_mem),
        .reset         (reset),
        .host_wr_en    (host_wr_en),
        .host_rd_req   (host_rd_req),
        .host_mat      (host_mat),
        .host_bank     (host_bank),
        .host_addr     (host_addr),
        .host_wdata    (host_wdata),
        .host_rdata    (host_rdata),
        .host_rd_valid (host_rd_valid),
        .host_err      (host_err),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .eng_a_addr    (eng_a_addr),
        .eng_a_data    (eng_a_data),
        .eng_b_addr    (eng_b_addr),
        .eng_b_data    (eng_b_data),
        .eng_c_valid   (eng_c_valid),
        .eng_c_data    (eng_c_data)
    );

    always #5 clk_mem = ~clk_mem;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [1:0]  mat;
        logic [1:0]  bank;
        logic [6:0]  addr;
        logic [15:0] seed;
        bit          lands;
        bit          exp_err;
        bit          exp_valid;
    } vec_t;

    typedef struct {
        logic [WW-1:0] data;
        int            due;
    } rd_exp_t;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    rd_exp_t       rd_q[$];
    bit            err_due[int];
    bit            done_due[int];
    logic [WW-1:0] model[int];
    vec_t          vecs[17];

    function automatic logic [WW-1:0] pat(input logic [15:0] x);
        logic [WW-1:0] w;
        for (int e = 0; e < int'(TL); e++) w[e*DW +: DW] = x ^ 16'(e);
        return w;
    endfunction

    function automatic logic [WW-1:0] cword(input int k, input int j);
        logic [WW-1:0] w;
        for (int e = 0; e < int'(TL); e++) w[e*DW +: DW] = {8'(k), 8'(j)};
        return w;
    endfunction

    function automatic int mkey(input logic [1:0] m, input logic [1:0] b, input logic [6:0] a);
        return int'(m) * 1024 + int'(b) * 128 + int'(a);
    endfunction

    task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    // Per-cycle scoreboard of the pulse/stream outputs.
    task automatic mon();
        rd_exp_t e;
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            e = rd_q.pop_front();
            chk("rd_valid", WW'(host_rd_valid), WW'(1));
            chk("rd_data", host_rdata, e.data);
        end else if (host_rd_valid) begin
            chk("rd_valid_unexpected", WW'(host_rd_valid), WW'(0));
        end
        if (err_due.exists(cyc) || host_err) begin
            chk("host_err", WW'(host_err), WW'(err_due.exists(cyc)));
            if (err_due.exists(cyc)) err_due.delete(cyc);
        end
        if (done_due.exists(cyc) || done) begin
            chk("done", WW'(done), WW'(done_due.exists(cyc)));
            if (done_due.exists(cyc)) done_due.delete(cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_mem);
        cyc++;
        @(negedge clk_mem);
        mon();
    endtask

    task automatic host_idle();
        host_wr_en  = 1'b0;
        host_rd_req = 1'b0;
    endtask

    task automatic host_read(input logic [1:0] m, input logic [1:0] b, input logic [6:0] a,
                             input logic [WW-1:0] exp);
        host_wr_en  = 1'b0;
        host_rd_req = 1'b1;
        host_mat    = m;
        host_bank   = b;
        host_addr   = a;
        rd_q.push_back('{data: exp, due: cyc + int'(RD_LAT)});
        tick();
        host_idle();
    endtask

    task automatic run_capture(input logic [7:0] tag, input int nbeats, input bit full);
        // start together with a legal host read: start wins, read dropped
        start       = 1'b1;
        host_rd_req = 1'b1;
        host_mat    = MAT_A;
        host_bank   = 2'd1;
        host_addr   = 7'd5;
        err_due[cyc + 1] = 1'b1;
        tick();
        start = 1'b0;
        host_idle();
        for (int b = 0; b < nbeats; b++) begin
            eng_c_valid = 1'b1;
            for (int k = 0; k < int'(NC); k++) eng_c_data[k*WW +: WW] = cword(k, b ^ int'(tag));
            if (b == 10) begin
                host_wr_en = 1'b1;
                host_mat   = MAT_A;
                host_bank  = 2'd1;
                host_addr  = 7'd5;
                host_wdata = pat(16'hDEAD);
                err_due[cyc + 1] = 1'b1;
            end
            start = (b == 30);
            if (full && b == int'(CR) - 1) done_due[cyc + 1] = 1'b1;
            tick();
            host_idle();
            start = 1'b0;
            if (b == 5) chk("busy_run", WW'(busy), WW'(1));
        end
        eng_c_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1, 0, MAT_A, 0, 5,   16'h5A5A, 1, 0, 0};
        vecs[1]  = '{1, 0, MAT_A, 1, 5,   16'h1234, 1, 0, 0};
        vecs[2]  = '{0, 1, MAT_A, 1, 5,   16'h0000, 0, 0, 1};
        vecs[3]  = '{0, 1, MAT_A, 0, 5,   16'h0000, 0, 0, 1};
        vecs[4]  = '{0, 1, 2'd3,  0, 5,   16'h0000, 0, 1, 0};
        vecs[5]  = '{0, 1, MAT_C, 2, 5,   16'h0000, 0, 1, 0};
        vecs[6]  = '{1, 0, MAT_B, 3, 9,   16'hBAD0, 0, 1, 0};
        vecs[7]  = '{1, 0, MAT_B, 0, 9,   16'h7777, 1, 0, 0};
        vecs[8]  = '{0, 1, MAT_B, 0, 9,   16'h0000, 0, 0, 1};
        vecs[9]  = '{1, 0, MAT_B, 1, 127, 16'hC0DE, 1, 0, 0};
        vecs[10] = '{0, 1, MAT_B, 1, 127, 16'h0000, 0, 0, 1};
        vecs[11] = '{1, 0, MAT_A, 0, 0,   16'h0F0F, 1, 0, 0};
        vecs[12] = '{0, 1, MAT_A, 0, 0,   16'h0000, 0, 0, 1};
        vecs[13] = '{1, 1, MAT_B, 0, 9,   16'h9999, 1, 1, 0};
        vecs[14] = '{0, 1, MAT_B, 0, 9,   16'h0000, 0, 0, 1};
        vecs[15] = '{1, 0, MAT_C, 1, 3,   16'h3C3C, 1, 0, 0};
        vecs[16] = '{0, 1, MAT_C, 1, 3,   16'h0000, 0, 0, 1};

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_busy", WW'(busy), WW'(0));
        chk("rst_done", WW'(done), WW'(0));
        chk("rst_rd_valid", WW'(host_rd_valid), WW'(0));
        chk("rst_err", WW'(host_err), WW'(0));
        chk("rst_rdata", host_rdata, '0);
        reset = 1'b0;
        tick();

        // Host vector table, issued back to back
        for (int i = 0; i < 17; i++) begin
            host_wr_en  = vecs[i].wr;
            host_rd_req = vecs[i].rd;
            host_mat    = vecs[i].mat;
            host_bank   = vecs[i].bank;
            host_addr   = vecs[i].addr;
            host_wdata  = pat(vecs[i].seed);
            if (vecs[i].lands) model[mkey(vecs[i].mat, vecs[i].bank, vecs[i].addr)] = pat(vecs[i].seed);
            if (vecs[i].exp_valid)
                rd_q.push_back('{data: model[mkey(vecs[i].mat, vecs[i].bank, vecs[i].addr)],
                                 due: cyc + int'(RD_LAT)});
            if (vecs[i].exp_err) err_due[cyc + 1] = 1'b1;
            tick();
        end
        host_idle();
        repeat (5) tick();

        // Engine read latency: address -> data in exactly three cycles
        eng_a_addr[AW +: AW] = 7'd5;
        eng_b_addr[AW +: AW] = 7'd127;
        tick();
        eng_a_addr = '0;
        eng_b_addr = '0;
        tick();
        tick();
        chk("eng_a1_data", eng_a_data[WW +: WW], pat(16'h1234));
        chk("eng_b1_data", eng_b_data[WW +: WW], pat(16'hC0DE));

        // Full capture run
        run_capture(8'h00, int'(CR), 1'b1);
        tick();
        chk("busy_after_done", WW'(busy), WW'(0));
        repeat (3) tick();
        for (int k = 0; k < int'(NC); k++) begin
            host_read(MAT_C, 2'(k), 7'd0, cword(k, 0));
            host_read(MAT_C, 2'(k), 7'd1, cword(k, 1));
            host_read(MAT_C, 2'(k), 7'd31, cword(k, 31));
            host_read(MAT_C, 2'(k), 7'd63, cword(k, 63));
        end
        host_read(MAT_A, 2'd1, 7'd5, pat(16'h1234));
        repeat (5) tick();

        // In-flight read cancelled by reset
        host_rd_req = 1'b1;
        host_mat    = MAT_A;
        host_bank   = 2'd0;
        host_addr   = 7'd5;
        tick();
        host_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (5) tick();

        // Reset after 20 beats: no done, then a fresh run recaptures from address 0
        run_capture(8'hA5, 20, 1'b0);
        chk("busy_partial", WW'(busy), WW'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("busy_after_reset", WW'(busy), WW'(0));
        repeat (10) tick();
        chk("busy_idle", WW'(busy), WW'(0));
        run_capture(8'h3C, int'(CR), 1'b1);
        repeat (4) tick();
        host_read(MAT_C, 2'd0, 7'd0, cword(0, 8'h3C));
        host_read(MAT_C, 2'd1, 7'd19, cword(1, 19 ^ 8'h3C));
        host_read(MAT_C, 2'd1, 7'd63, cword(1, 63 ^ 8'h3C));
        repeat (6) tick();

        chk("rd_queue_drained", WW'(rd_q.size()), WW'(0));
        chk("err_all_seen", WW'(err_due.size()), WW'(0));
        chk("done_all_seen", WW'(done_due.size()), WW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/matmul_tile_mem_ctrl.md
Name: matmul_tile_mem_ctrl

Overview:
- Parametrised memory subsystem for tiled fp16 systolic matmul arrays.
- Holds NUM_A A-banks, NUM_B B-banks and NUM_C C-banks, each a single-port RAM with TILE*DWIDTH-bit words.
- Arbitrates host load/readback against engine reads and C-row capture.
- Unlike the previous fixed 2x2 wrapper: host writes are bank-addressed rather than broadcast, C capture is counted internally, and a run FSM blocks host access while the engine runs.

Parameters:
- DWIDTH, 16, element width (fp16).
- TILE, 32, elements per RAM word.
- AWIDTH, 7, RAM address width; depth = 2**AWIDTH.
- NUM_A, 2, A-bank count.
- NUM_B, 2, B-bank count.
- NUM_C, 2, C-bank count; also the number of C rows delivered per engine beat.
- C_ROWS, 64, C beats captured per run (1..2**AWIDTH).
- BSEL_W, 2, host bank-select width; must be >= clog2(max(NUM_A,NUM_B,NUM_C)).

Ports:
- clk_mem  in  1  clock
- reset  in  1  synchronous, active-high reset
- host_wr_en  in  1  host write strobe
- host_rd_req  in  1  host read request
- host_mat  in  2  target matrix: 0=A, 1=B, 2=C, 3=illegal
- host_bank  in  BSEL_W  bank index within host_mat
- host_addr  in  AWIDTH  word address
- host_wdata  in  TILE*DWIDTH  write data
- host_rdata  out  TILE*DWIDTH  read data
- host_rd_valid  out  1  read data valid pulse
- host_err  out  1  dropped-request pulse
- start  in  1  run start pulse
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when capture completes
- eng_a_addr  in  NUM_A*AWIDTH  engine A read addresses
- eng_a_data  out  NUM_A*TILE*DWIDTH  A read data
- eng_b_addr  in  NUM_B*AWIDTH  engine B read addresses
- eng_b_data  out  NUM_B*TILE*DWIDTH  B read data
- eng_c_valid  in  1  C beat valid
- eng_c_data  in  NUM_C*TILE*DWIDTH  C rows; row k is written to C-bank k

Behaviour:
- Clock and reset: everything runs on clk_mem. reset is synchronous, active-high.
- Reset values: all outputs 0, FSM=IDLE, c_wptr=0, all pipeline registers 0. RAM contents are not cleared.
- FSM states:
  - IDLE: host access is allowed. start moves to RUN and clears c_wptr to 0. A start in the same cycle as a host request is honoured; the host request is dropped with host_err.
  - RUN: busy=1. Each eng_c_valid writes eng_c_data row k to C-bank k at c_wptr, then c_wptr increments. The beat at c_wptr==C_ROWS-1 moves to DONE. start in RUN is ignored.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Host write (IDLE only):
  - One cycle to register, then the RAM write the following cycle.
  - host_mat==3, or host_bank >= bank count for the selected matrix: write dropped, host_err pulses one cycle later.
- Host read (IDLE only):
  - Path: request registered, then RAM read, then output register.
  - host_rdata and host_rd_valid appear exactly 3 cycles after the request cycle.
  - Illegal selects: no valid, host_err pulses.
  - host_rdata holds its last value when valid=0.
- Simultaneous host_wr_en and host_rd_req: the write is performed, the read is dropped, host_err pulses.
- Any host request in RUN or DONE: dropped, host_err pulses. Back-to-back requests are fully pipelined, 1 per cycle.
- Engine reads:
  - Address mux per A/B bank: registered host address when a host access targets that bank, otherwise the registered eng_*_addr.
  - eng_*_data is registered, giving address-to-data latency of 3 cycles.
  - Engine reads are active in all states.
- C address mux: the registered host address during host access; otherwise c_wptr. C write data is registered one cycle, aligned with the address register.
- c_wptr width is AWIDTH. Completion occurs before wrap, because C_ROWS <= 2**AWIDTH.
- Reset mid-RUN: returns to IDLE with no done pulse. Partially captured C data remains in RAM.
- In-flight host reads at reset are cancelled: no valid is asserted after reset.

Decomposition:
- Shared package mtm_pkg holds:
  - host_mat encodings MAT_A/MAT_B/MAT_C;
  - state enum IDLE/RUN/DONE;
  - RD_LAT=3.
- One sub-module, mtm_bank: single-port RAM (reuses single_port_ram) plus its registered address mux and registered output. It is instantiated NUM_A+NUM_B+NUM_C times via generate.

Test Plan:
- Write A-bank1 addr 5 = 0x1234-pattern, read A-bank1 addr 5 -> host_rd_valid at +3 cycles with the pattern; A-bank0 addr 5 is unchanged (no broadcast).
- Read with host_mat=3, and with host_mat=C bank=2 when NUM_C=2 -> no valid; host_err pulses once each.
- start, then 64 eng_c_valid beats with row k = {k,beat} -> done pulses exactly once after beat 63; readback of C bank k addr j returns {k,j}.
- Host write during RUN -> host_err pulses and the target word is unchanged after done.
- Simultaneous wr+rd to B-bank0 -> write lands, no rd_valid, host_err=1.
- Reset after 20 C beats -> busy=0, done never pulses; a new start recaptures from c_wptr=0.
